// File: rtl/dil_w1_pkg.sv
// Shared constants, level decode and FSM state type for the w1' bit-packer.
`timescale 1ns/1ps
package dil_w1_pkg;

  localparam int W1_COEFF_W   = 24;
  localparam int W1_IN_COEFFS = 4;
  localparam int W1_W         = 64;
  localparam int ACC_W        = 88;
  localparam int FILL_W       = 7;
  localparam int BEAT_CNT_W   = 10;
  localparam int WORD_CNT_W   = 8;

  localparam int LVL2_K     = 4;
  localparam int LVL2_B     = 6;
  localparam int LVL2_BEATS = 256;
  localparam int LVL2_WORDS = 96;

  localparam int LVL3_K     = 6;
  localparam int LVL3_B     = 4;
  localparam int LVL3_BEATS = 384;
  localparam int LVL3_WORDS = 96;

  localparam int LVL5_K     = 8;
  localparam int LVL5_B     = 4;
  localparam int LVL5_BEATS = 512;
  localparam int LVL5_WORDS = 128;

  localparam logic [W1_COEFF_W-1:0] W1_MAX_LVL2  = 24'd43;
  localparam logic [W1_COEFF_W-1:0] W1_MAX_LVL35 = 24'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PACK = 2'd1,
    ST_DONE = 2'd2
  } w1_state_e;

  typedef struct packed {
    logic                  lvl2;
    logic [BEAT_CNT_W-1:0] beats;
    logic [WORD_CNT_W-1:0] words;
  } w1_lvl_cfg_t;

  // Unknown security levels fall back to the level-5 geometry.
  function automatic w1_lvl_cfg_t lvl_decode(input logic [2:0] sec_lvl);
    w1_lvl_cfg_t cfg;
    case (sec_lvl)
      3'd2:    cfg = '{lvl2: 1'b1, beats: BEAT_CNT_W'(LVL2_BEATS), words: WORD_CNT_W'(LVL2_WORDS)};
      3'd3:    cfg = '{lvl2: 1'b0, beats: BEAT_CNT_W'(LVL3_BEATS), words: WORD_CNT_W'(LVL3_WORDS)};
      default: cfg = '{lvl2: 1'b0, beats: BEAT_CNT_W'(LVL5_BEATS), words: WORD_CNT_W'(LVL5_WORDS)};
    endcase
    return cfg;
  endfunction

endpackage

// File: rtl/w1_coeff_compress.sv
// Combinational 4-lane truncate/concatenate of w1' coefficients into one beat field.
// Range flags are only built when W1_RANGE_CHECK_EN is defined.
`timescale 1ns/1ps
module w1_coeff_compress
  import dil_w1_pkg::*;
(
  input  logic [W1_COEFF_W*W1_IN_COEFFS-1:0] i_coeffs,
  input  logic                               i_lvl2,
  output logic [23:0]                        o_field,
  output logic [3:0]                         o_coeff_b,
  output logic [W1_IN_COEFFS-1:0]            o_range_err
);

  logic [W1_COEFF_W-1:0] w_c [W1_IN_COEFFS];

  for (genvar j = 0; j < W1_IN_COEFFS; j++) begin : g_lane
    assign w_c[j] = i_coeffs[j*W1_COEFF_W +: W1_COEFF_W];
  end

  always_comb begin
    o_field = '0;
    if (i_lvl2) begin
      o_field = {w_c[3][5:0], w_c[2][5:0], w_c[1][5:0], w_c[0][5:0]};
    end else begin
      o_field = {8'h00, w_c[3][3:0], w_c[2][3:0], w_c[1][3:0], w_c[0][3:0]};
    end
  end

  assign o_coeff_b = i_lvl2 ? 4'd6 : 4'd4;

`ifdef W1_RANGE_CHECK_EN
  for (genvar j = 0; j < W1_IN_COEFFS; j++) begin : g_range
    assign o_range_err[j] = w_c[j] > (i_lvl2 ? W1_MAX_LVL2 : W1_MAX_LVL35);
  end
`else
  assign o_range_err = '0;
  // Truncated-away coefficient bits have no consumer without the range check.
  logic w_unused_hi;
  assign w_unused_hi = ^{w_c[0][23:6], w_c[1][23:6], w_c[2][23:6], w_c[3][23:6]};
`endif

endmodule

// File: rtl/w1_pack.sv
// Dilithium verify w1' packer: 4 coefficients per beat in, 64-bit LE words out.
// Optional sticky range check on input lanes is enabled by W1_RANGE_CHECK_EN.
`timescale 1ns/1ps
module w1_pack
  import dil_w1_pkg::*;
#(
  parameter int COEFF_W   = W1_COEFF_W,
  parameter int IN_COEFFS = W1_IN_COEFFS,
  parameter int W         = W1_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [2:0]                   sec_lvl,
  input  logic [COEFF_W*IN_COEFFS-1:0] poly_i,
  input  logic                         poly_valid_i,
  output logic                         poly_ready_i,
  output logic [W-1:0]                 do_o,
  output logic                         valid_o,
  input  logic                         ready_o,
  output logic                         last_o,
  output logic                         done,
  output logic                         err_o
);

  w1_state_e             r_state;
  w1_state_e             w_state_nxt;
  logic                  r_lvl2;
  logic [BEAT_CNT_W-1:0] r_total_beats;
  logic [BEAT_CNT_W-1:0] r_beats_in;
  logic [WORD_CNT_W-1:0] r_total_words;
  logic [WORD_CNT_W-1:0] r_words_out;
  logic [ACC_W-1:0]      r_acc;
  logic [FILL_W-1:0]     r_fill;

  w1_lvl_cfg_t           w_cfg;
  logic [23:0]           w_field;
  logic [3:0]            w_coeff_b;
  logic [3:0]            w_range_err;
  logic                  w_start_job;
  logic                  w_accept;
  logic                  w_pop;
  logic                  w_last_word;

  w1_coeff_compress u_compress (
    .i_coeffs    (poly_i),
    .i_lvl2      (r_lvl2),
    .o_field     (w_field),
    .o_coeff_b   (w_coeff_b),
    .o_range_err (w_range_err)
  );

  assign w_cfg       = lvl_decode(sec_lvl);
  assign w_start_job = (r_state == ST_IDLE) && start;

  // Ready depends only on registered state; ready_o never reaches it.
  assign poly_ready_i = (r_state == ST_PACK) && (r_fill < 7'd64) && (r_beats_in < r_total_beats);
  assign valid_o      = (r_state == ST_PACK) && (r_fill >= 7'd64);
  assign do_o         = r_acc[W-1:0];
  assign w_last_word  = (r_words_out == r_total_words - 8'd1);
  assign last_o       = valid_o && w_last_word;
  assign done         = (r_state == ST_DONE);

  assign w_accept = poly_ready_i && poly_valid_i;
  assign w_pop    = valid_o && ready_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_PACK;
      ST_PACK: if (w_pop && w_last_word) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Accept and pop are mutually exclusive: accept needs fill<64, pop needs fill>=64.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lvl2        <= 1'b0;
      r_total_beats <= '0;
      r_total_words <= '0;
      r_beats_in    <= '0;
      r_words_out   <= '0;
      r_acc         <= '0;
      r_fill        <= '0;
    end else if (w_start_job) begin
      r_lvl2        <= w_cfg.lvl2;
      r_total_beats <= w_cfg.beats;
      r_total_words <= w_cfg.words;
      r_beats_in    <= '0;
      r_words_out   <= '0;
      r_acc         <= '0;
      r_fill        <= '0;
    end else if (w_accept) begin
      r_acc      <= r_acc | (ACC_W'(w_field) << r_fill);
      r_fill     <= r_fill + {1'b0, w_coeff_b, 2'b00};
      r_beats_in <= r_beats_in + 10'd1;
    end else if (w_pop) begin
      r_acc       <= r_acc >> W;
      r_fill      <= r_fill - 7'd64;
      r_words_out <= r_words_out + 8'd1;
    end
  end

`ifdef W1_RANGE_CHECK_EN
  logic r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_start_job) begin
      r_err <= 1'b0;
    end else if (w_accept && (|w_range_err)) begin
      r_err <= 1'b1;
    end
  end

  assign err_o = r_err;
`else
  assign err_o = 1'b0;
  logic w_unused_range;
  assign w_unused_range = |w_range_err;
`endif

endmodule

// File: tb/tb_w1_pack.sv
// Scoreboard bench for w1_pack: driver pushes expected words, negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_w1_pack;

  localparam int K_ALL15  = 0;
  localparam int K_1234   = 1;
  localparam int K_PAT    = 2;
  localparam int K_BAD    = 3;
  localparam int BAD_BEAT = 10;
  localparam int BAD_LANE = 2;
  localparam int BUDGET   = 4000;
`ifdef W1_RANGE_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  sec_lvl = 3'd0;
  logic [95:0] poly_i = '0;
  logic        poly_valid_i = 1'b0;
  logic        poly_ready_i;
  logic [63:0] do_o;
  logic        valid_o;
  logic        ready_o = 1'b0;
  logic        last_o;
  logic        done;
  logic        err_o;

  w1_pack dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .sec_lvl      (sec_lvl),
    .poly_i       (poly_i),
    .poly_valid_i (poly_valid_i),
    .poly_ready_i (poly_ready_i),
    .do_o         (do_o),
    .valid_o      (valid_o),
    .ready_o      (ready_o),
    .last_o       (last_o),
    .done         (done),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [63:0] word;
    logic        last;
  } exp_t;

  exp_t        sb_q[$];
  int          kind_cur = 0;
  int          job_words = 0;
  int          job_base = 0;
  int          words_seen = 0;
  int          dones_seen = 0;
  int          lasts_seen = 0;
  logic        mon_en = 1'b0;
  logic        hs_last_prev = 1'b0;
  logic        hold_prev = 1'b0;
  logic [63:0] hold_word = '0;
  logic [63:0] hand2 [0:2];

  function automatic logic [23:0] coef(input int kind, input int beat, input int lane, input bit lvl2);
    if (kind == K_ALL15) return 24'd15;
    if (kind == K_1234) return 24'(lane + 1);
    if (kind == K_BAD && beat == BAD_BEAT && lane == BAD_LANE) return 24'd16;
    return 24'((((beat * 4 + lane) * 37) + 5) % (lvl2 ? 44 : 16));
  endfunction

  function automatic logic [95:0] beat_vec(input int kind, input int beat, input bit lvl2);
    logic [95:0] v;
    v = '0;
    for (int l = 0; l < 4; l++) v[l*24 +: 24] = coef(kind, beat, l, lvl2);
    return v;
  endfunction

  // Monitor: compares every output handshake, checks hold under backpressure and done timing.
  always @(negedge clk) begin
    exp_t e;
    int   idx;
    if (!mon_en) begin
      hs_last_prev = 1'b0;
      hold_prev    = 1'b0;
    end else begin
      if (hs_last_prev || done) check("done_pulse", done, hs_last_prev);
      if (done) dones_seen++;
      if (hold_prev) begin
        check("hold_valid", valid_o, 1'b1);
        check("hold_do", do_o, hold_word);
      end
      hs_last_prev = 1'b0;
      hold_prev    = 1'b0;
      if (valid_o && ready_o) begin
        idx = words_seen - job_base;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow word=%0d actual=%h required=none", idx, do_o);
        end else begin
          e = sb_q.pop_front();
          check($sformatf("word%0d", idx), do_o, e.word);
          check($sformatf("last%0d", idx), last_o, e.last);
        end
        if (kind_cur == K_1234 && idx < 3) check($sformatf("lvl2_hand%0d", idx), do_o, hand2[idx]);
        if (kind_cur == K_ALL15) check("lvl3_ones", do_o, 64'hFFFF_FFFF_FFFF_FFFF);
        words_seen++;
        if (last_o) lasts_seen++;
        hs_last_prev = ((words_seen - job_base) == job_words);
      end else if (valid_o) begin
        hold_prev = 1'b1;
        hold_word = do_o;
      end
    end
  end

  task automatic run_job(input logic [2:0] lvl, input int kind, input int stall_at,
                         input int abort_at, input int mid_start_at);
    int   nb;
    int   nw;
    int   b;
    bit   l2;
    int   beat_idx;
    int   pops;
    int   cyc;
    int   stall_left;
    int   base_d;
    int   base_l;
    bit   acc;
    bit   stalled;
    bit   err_next;
    bit   mid_done;
    logic stream [0:8191];
    logic [23:0] c;
    logic [63:0] wd;

    l2 = (lvl == 3'd2);
    if (lvl == 3'd2) begin nb = 256; nw = 96;  b = 6; end
    else if (lvl == 3'd3) begin nb = 384; nw = 96;  b = 4; end
    else begin nb = 512; nw = 128; b = 4; end

    // Software reference: coefficient n occupies stream bits [n*B, n*B+B).
    for (int i = 0; i < 8192; i++) stream[i] = 1'b0;
    for (int n = 0; n < nb * 4; n++) begin
      c = coef(kind, n / 4, n % 4, l2);
      for (int k = 0; k < b; k++) stream[n*b + k] = c[k];
    end
    for (int w = 0; w < nw; w++) begin
      for (int k = 0; k < 64; k++) wd[k] = stream[w*64 + k];
      sb_q.push_back('{word: wd, last: (w == nw - 1)});
    end

    kind_cur  = kind;
    job_words = nw;
    job_base  = words_seen;
    base_d    = dones_seen;
    base_l    = lasts_seen;
    beat_idx  = 0;
    pops      = 0;
    cyc       = 0;
    stall_left = 0;
    stalled   = 1'b0;
    err_next  = 1'b0;
    mid_done  = 1'b0;

    @(posedge clk); #1;
    sec_lvl = lvl;
    start   = 1'b1;
    @(posedge clk); #1;
    start        = 1'b0;
    check("err_clear_on_start", err_o, 1'b0);
    poly_valid_i = 1'b1;
    poly_i       = beat_vec(kind, 0, l2);
    ready_o      = 1'b1;

    while (cyc < BUDGET) begin
      @(negedge clk);
      acc = poly_ready_i && poly_valid_i;
      if (err_next) begin
        check("err_rise", err_o, EXP_ERR);
        err_next = 1'b0;
      end
      if (acc && kind == K_BAD && beat_idx == BAD_BEAT) begin
        check("err_before", err_o, 1'b0);
        err_next = 1'b1;
      end
      if (!ready_o) begin
        check("stall_valid", valid_o, 1'b1);
        check("stall_in_ready", poly_ready_i, 1'b0);
      end
      if (valid_o && ready_o) pops++;
      if (abort_at >= 0 && pops >= abort_at) begin
        mon_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_valid", valid_o, 1'b0);
        check("rst_in_ready", poly_ready_i, 1'b0);
        check("rst_last", last_o, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_do", do_o, 64'h0);
        sb_q.delete();
        poly_valid_i = 1'b0;
        ready_o      = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_rst", poly_ready_i, 1'b0);
        mon_en = 1'b1;
        return;
      end
      if (stall_at >= 0 && !stalled && pops >= stall_at && acc &&
          ((beat_idx + 1) * 4 * b - pops * 64) >= 64) begin
        stall_left = 5;
        stalled    = 1'b1;
      end
      if (dones_seen > base_d) break;
      @(posedge clk); #1;
      cyc++;
      if (acc) beat_idx++;
      poly_i = (beat_idx < nb) ? beat_vec(kind, beat_idx, l2) : '0;
      poly_valid_i = !(kind == K_1234 && (cyc % 7) == 3);
      ready_o = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      if (mid_done) begin
        start   = 1'b0;
        sec_lvl = lvl;
      end
      if (mid_start_at >= 0 && !mid_done && pops >= mid_start_at) begin
        start    = 1'b1;
        sec_lvl  = 3'd2;
        mid_done = 1'b1;
      end
    end

    if (cyc >= BUDGET) begin
      checks++;
      errors++;
      $display("FAIL job_timeout actual=%0d cycles required=done before %0d", cyc, BUDGET);
    end
    poly_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    check("beats_accepted", 64'(beat_idx), 64'(nb));
    check("words_popped", 64'(pops), 64'(nw));
    check("words_seen", 64'(words_seen - job_base), 64'(nw));
    check("done_count", 64'(dones_seen - base_d), 64'd1);
    check("last_count", 64'(lasts_seen - base_l), 64'd1);
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    check("idle_valid", valid_o, 1'b0);
    check("idle_in_ready", poly_ready_i, 1'b0);
    check("err_end", err_o, (kind == K_BAD) ? EXP_ERR : 1'b0);
    if (stall_at >= 0) check("stall_happened", stalled, 1'b1);
  endtask

  initial begin
    hand2[0] = 64'h3081_1030_8110_3081;
    hand2[1] = 64'h8110_3081_1030_8110;
    hand2[2] = 64'h1030_8110_3081_1030;

    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", valid_o, 1'b0);
    check("reset_in_ready", poly_ready_i, 1'b0);
    check("reset_last", last_o, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_err", err_o, 1'b0);
    check("reset_do", do_o, 64'h0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready0", poly_ready_i, 1'b0);
    mon_en = 1'b1;

    run_job(3'd3, K_ALL15, -1, -1, -1);
    run_job(3'd2, K_1234,  -1, -1, -1);
    run_job(3'd5, K_PAT,   20, -1, -1);
    run_job(3'd5, K_BAD,   -1, -1, -1);
    run_job(3'd3, K_PAT,   -1, 40, -1);
    run_job(3'd3, K_PAT,   -1, -1, -1);
    run_job(3'd7, K_PAT,   -1, -1, 30);
    run_job(3'd2, K_PAT,   -1, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
